product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator_pkg.sv | 23 ++
 rtl/product_accumulator_sat_add.sv | 41 ++++
 rtl/product_accumulator.sv | 104 ++++++++++
 tb/tb_product_accumulator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator.
//   state_e  : FSM state encoding (2 bits)
//   PROD_W   : width of the signed product from the upstream multiplier
//   acc_max/acc_min : signed limits of an acc_w-bit two's-complement value
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_e;

  localparam int PROD_W = 8;

  function automatic int acc_max(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

  function automatic int acc_min(input int acc_w);
    return -(1 << (acc_w - 1));
  endfunction

endpackage

// File: rtl/product_accumulator_sat_add.sv
// sat_add: combinational signed saturating adder.
//   acc_i    : ACC_W-bit signed accumulator value
//   addend_i : PROD_W-bit signed addend
//   sum_o    : acc_i + addend_i clamped to the ACC_W signed range
//   ovf_o    : high when clamping was applied
module sat_add
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] addend_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  localparam logic signed [ACC_W:0] MAX_W = (ACC_W+1)'(acc_max(ACC_W));
  localparam logic signed [ACC_W:0] MIN_W = (ACC_W+1)'(acc_min(ACC_W));

  logic signed [ACC_W:0] acc_x;
  logic signed [ACC_W:0] add_x;
  logic signed [ACC_W:0] wide;

  // One extra bit is enough: |addend| <= 128 is far below the ACC_W range.
  assign acc_x = {acc_i[ACC_W-1], acc_i};
  assign add_x = {{(ACC_W + 1 - PROD_W){addend_i[PROD_W-1]}}, addend_i};
  assign wide  = acc_x + add_x;

  always_comb begin
    sum_o = wide[ACC_W-1:0];
    ovf_o = 1'b0;
    if (wide > MAX_W) begin
      sum_o = MAX_W[ACC_W-1:0];
      ovf_o = 1'b1;
    end else if (wide < MIN_W) begin
      sum_o = MIN_W[ACC_W-1:0];
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: accumulates a burst of signed 8-bit products with
// saturation and presents the result through a valid/ready handshake.
//   clk, rst_n             : clock, asynchronous active-low reset
//   start, len             : begin a burst of len products (0 = 2^LEN_W)
//   in_valid/in_ready      : product input handshake, in_product data
//   out_valid/out_ready    : result handshake, out_sum / out_sat data
//   busy                   : FSM is not in IDLE
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = 10,
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic              busy
);

  localparam logic [LEN_W:0] REM_FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0] REM_ONE  = {{LEN_W{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [LEN_W:0]   rem_q, rem_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc_i    (acc_q),
    .addend_i (in_product),
    .sum_o    (add_sum),
    .ovf_o    (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          rem_d   = (len == '0) ? REM_FULL : {1'b0, len};
          acc_d   = '0;
          sat_d   = 1'b0;
        end
      end
      ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone marks a transfer.
        if (in_valid) begin
          acc_d = add_sum;
          sat_d = sat_q | add_ovf;
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the next state, so they line
  // up with state_q and carry no combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      in_ready_q  <= (state_d == ACCUM);
      out_valid_q <= (state_d == HOLD);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = acc_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_product;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_sum;
  logic       out_sat;
  logic       busy;

  int checks = 0;
  int errors = 0;

  product_accumulator #(.ACC_W(10), .LEN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_sat    (out_sat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one product and hold it until the block accepts it (bounded).
  task automatic send(input logic signed [7:0] p);
    bit done;
    done = 1'b0;
    in_valid   = 1'b1;
    in_product = p;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", {31'b0, in_ready}, 1);
  endtask

  task automatic begin_burst(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int sum, input int sat);
    chk({tag, "_valid"}, {31'b0, out_valid}, 1);
    chk({tag, "_sum"}, $signed(out_sum), sum);
    chk({tag, "_sat"}, {31'b0, out_sat}, sat);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_product = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  {31'b0, in_ready},  0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_sum",   $signed(out_sum),   0);
    chk("rst_out_sat",   {31'b0, out_sat},   0);
    chk("rst_busy",      {31'b0, busy},      0);
    step();

    // Basic burst; start honoured on the first edge after release.
    rst_n = 1'b1; out_ready = 1'b1;
    begin_burst(4'd3);
    chk("first_start_busy", {31'b0, busy}, 1);
    chk("first_start_ready", {31'b0, in_ready}, 1);
    send(8'sd10);
    send(-8'sd4);
    chk("basic_no_early_valid", {31'b0, out_valid}, 0);
    send(8'sd7);
    check_result("basic", 13, 0);
    chk("basic_ready_low", {31'b0, in_ready}, 0);
    step();
    chk("basic_valid_drop", {31'b0, out_valid}, 0);
    chk("basic_idle", {31'b0, busy}, 0);

    // Positive saturation: 127*5 clamps at 511.
    begin_burst(4'd5);
    repeat (5) send(8'sd127);
    check_result("pos_sat", 511, 1);
    step();

    // Negative saturation: -128*5 clamps at -512.
    begin_burst(4'd5);
    repeat (5) send(-8'sd128);
    check_result("neg_sat", -512, 1);
    step();

    // Sticky flag: from clamped 511, -128 gives 383 with sat still set.
    begin_burst(4'd6);
    repeat (5) send(8'sd127);
    send(-8'sd128);
    check_result("sticky", 383, 1);
    step();

    // len=0 means 16 products; count accepted transfers.
    begin_burst(4'd0);
    in_valid = 1'b1; in_product = 8'sd1; cnt = 0;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      if (in_ready) cnt++;
      step();
    end
    in_valid = 1'b0;
    chk("len0_count", cnt, 16);
    check_result("len0", 16, 0);
    step();

    // Gaps in in_valid, result held under back-pressure, start in HOLD ignored.
    out_ready = 1'b0;
    begin_burst(4'd3);
    step();
    send(8'sd10);
    step(); step();
    send(-8'sd4);
    step();
    send(8'sd7);
    check_result("gap", 13, 0);
    start = 1'b1; len = 4'd1;
    repeat (5) step();
    start = 1'b0;
    check_result("hold_stable", 13, 0);
    chk("hold_busy", {31'b0, busy}, 1);
    out_ready = 1'b1;
    step();
    chk("hold_release_valid", {31'b0, out_valid}, 0);
    chk("hold_release_busy", {31'b0, busy}, 0);
    step();
    chk("no_phantom_burst", {31'b0, busy}, 0);

    // Mid-burst asynchronous reset after 2 of 4 transfers.
    begin_burst(4'd4);
    send(8'sd5);
    send(8'sd3);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready",  {31'b0, in_ready},  0);
    chk("mrst_out_valid", {31'b0, out_valid}, 0);
    chk("mrst_out_sum",   $signed(out_sum),   0);
    chk("mrst_out_sat",   {31'b0, out_sat},   0);
    chk("mrst_busy",      {31'b0, busy},      0);
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_no_result", {31'b0, out_valid}, 0);
    begin_burst(4'd1);
    send(-8'sd6);
    check_result("post_rst", -6, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
